// File: rtl/c17_pkg.sv
// Shared types for the c17 netlist block.
package c17_pkg;

  // Primary input vector ordering: {gat1, gat2, gat3, gat6, gat7}
  typedef logic [4:0] c17_vec_t;

  // Primary output pair ordering: {gat_out22, gat_out23}
  typedef logic [1:0] c17_out_t;

  localparam int unsigned C17_NUM_INPUTS  = 5;
  localparam int unsigned C17_NUM_OUTPUTS = 2;

endpackage

// File: rtl/c17_nand2.sv
// Two-input NAND gate used as the sole primitive of the c17 netlist.
module c17_nand2 (
  input  logic a,
  input  logic b,
  output logic y
);

  // Single NAND function
  always_comb begin
    y = ~(a & b);
  end

endmodule

// File: rtl/c17.sv
// ISCAS-85 c17: six NAND gates, combinational outputs plus a registered copy.
module c17
  import c17_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic gat1,
  input  logic gat2,
  input  logic gat3,
  input  logic gat6,
  input  logic gat7,
  output logic gat_out22,
  output logic gat_out23,
  output logic gat_out22_q,
  output logic gat_out23_q
);

  logic     n10;
  logic     n11;
  logic     n16;
  logic     n19;
  logic     n22;
  logic     n23;
  c17_out_t out_q;

  c17_nand2 u_n10 (.a(gat1), .b(gat3), .y(n10));
  c17_nand2 u_n11 (.a(gat3), .b(gat6), .y(n11));
  c17_nand2 u_n16 (.a(gat2), .b(n11),  .y(n16));
  c17_nand2 u_n19 (.a(n11),  .b(gat7), .y(n19));
  c17_nand2 u_n22 (.a(n10),  .b(n16),  .y(n22));
  c17_nand2 u_n23 (.a(n16),  .b(n19),  .y(n23));

  // Combinational outputs come straight from the gate network, independent of the register stage
  always_comb begin
    gat_out22 = n22;
    gat_out23 = n23;
  end

  // Output register stage, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= {n22, n23};
    end
  end

  // Expose registered pair on individual ports
  always_comb begin
    gat_out22_q = out_q[1];
    gat_out23_q = out_q[0];
  end

endmodule

// File: tb/tb_c17.sv
// Directed self-checking bench for c17.
module tb_c17;

  logic clk;
  logic rst;
  logic gat1, gat2, gat3, gat6, gat7;
  logic gat_out22, gat_out23, gat_out22_q, gat_out23_q;

  int n_cmp;
  int n_bad;

  c17 dut (
    .clk        (clk),
    .rst        (rst),
    .gat1       (gat1),
    .gat2       (gat2),
    .gat3       (gat3),
    .gat6       (gat6),
    .gat7       (gat7),
    .gat_out22  (gat_out22),
    .gat_out23  (gat_out23),
    .gat_out22_q(gat_out22_q),
    .gat_out23_q(gat_out23_q)
  );

  // One full clock period: rising edge at +5, falling edge at +10
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  // Input vector order: {gat1, gat2, gat3, gat6, gat7}
  task automatic apply(input logic [4:0] v);
    {gat1, gat2, gat3, gat6, gat7} = v;
  endtask

  // Directed combinational vectors, clk idle, checked 10 ns after each change
  task automatic test_comb_vectors();
    logic [4:0] vin  [5];
    logic [1:0] vexp [5];
    vin[0] = 5'b00000; vexp[0] = 2'b00;
    vin[1] = 5'b10101; vexp[1] = 2'b11;
    vin[2] = 5'b01010; vexp[2] = 2'b11;
    vin[3] = 5'b11011; vexp[3] = 2'b11;
    vin[4] = 5'b11111; vexp[4] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      apply(vin[i]);
      #10;
      n_cmp++;
      if ({gat_out22, gat_out23} !== vexp[i]) begin
        n_bad++;
        $display("FAIL comb_vec in=%b got out22,out23=%b expected %b",
                 vin[i], {gat_out22, gat_out23}, vexp[i]);
      end
    end
  endtask

  // Exhaustive sweep against sum-of-products form of the netlist
  task automatic test_exhaustive();
    logic [4:0] v;
    logic       g1, g2, g3, g6, g7, e22, e23;
    for (int i = 0; i < 32; i++) begin
      v = i[4:0];
      {g1, g2, g3, g6, g7} = v;
      e22 = (g1 & g3) | (g2 & ~(g3 & g6));
      e23 = ~(g3 & g6) & (g2 | g7);
      apply(v);
      #10;
      n_cmp++;
      if ({gat_out22, gat_out23} !== {e22, e23}) begin
        n_bad++;
        $display("FAIL sweep in=%b got %b expected %b",
                 v, {gat_out22, gat_out23}, {e22, e23});
      end
    end
  endtask

  // Asynchronous reset clears registered outputs without a clock edge
  task automatic test_reset();
    rst = 1'b0;
    apply(5'b11111);
    #2;
    tick();
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b10) begin
      n_bad++;
      $display("FAIL preload_q got %b expected 10", {gat_out22_q, gat_out23_q});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_async got %b expected 00", {gat_out22_q, gat_out23_q});
    end
    tick();
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_hold got %b expected 00", {gat_out22_q, gat_out23_q});
    end
    n_cmp++;
    if ({gat_out22, gat_out23} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_comb got %b expected 10", {gat_out22, gat_out23});
    end
    rst = 1'b0;
    apply(5'b11111);
    #1;
    tick();
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b10) begin
      n_bad++;
      $display("FAIL first_capture got %b expected 10", {gat_out22_q, gat_out23_q});
    end
  endtask

  // Registered outputs lag inputs by one edge; combinational outputs follow at once
  task automatic test_latency();
    apply(5'b00000);
    #1;
    n_cmp++;
    if ({gat_out22, gat_out23} !== 2'b00) begin
      n_bad++;
      $display("FAIL latency_comb got %b expected 00", {gat_out22, gat_out23});
    end
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b10) begin
      n_bad++;
      $display("FAIL latency_hold got %b expected 10", {gat_out22_q, gat_out23_q});
    end
    tick();
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b00) begin
      n_bad++;
      $display("FAIL latency_update got %b expected 00", {gat_out22_q, gat_out23_q});
    end
  endtask

  // Reset pulse between edges while registers hold 1,1
  task automatic test_mid_reset();
    apply(5'b10101);
    #1;
    tick();
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_load got %b expected 11", {gat_out22_q, gat_out23_q});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_clear got %b expected 00", {gat_out22_q, gat_out23_q});
    end
    n_cmp++;
    if ({gat_out22, gat_out23} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_comb got %b expected 11", {gat_out22, gat_out23});
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_release got %b expected 00", {gat_out22_q, gat_out23_q});
    end
    tick();
    n_cmp++;
    if ({gat_out22_q, gat_out23_q} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_recapture got %b expected 11", {gat_out22_q, gat_out23_q});
    end
  endtask

  // Test sequence
  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk   = 1'b0;
    rst   = 1'b0;
    apply(5'b00000);
    test_comb_vectors();
    test_exhaustive();
    test_reset();
    test_latency();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
